// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronise, debounce and queue change events for N raw switch contacts
// Ports: clock, reset (async, active-high); SW raw contacts; STATE debounced levels;
//   RISE/FALL one-cycle strobes on STATE edges; EVENT_VALID/READY/INDEX/LEVEL change-event stream;
//   OVERRUN sticky flag set when an unconsumed event for a channel is overwritten.
module switch_debouncer #(
  parameter int N = 6,
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W = $clog2(STABLE_CYCLES + 1)
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] SW,
  output logic [N-1:0] STATE,
  output logic [N-1:0] RISE,
  output logic [N-1:0] FALL,
  output logic         EVENT_VALID,
  input  logic         EVENT_READY,
  output logic [3:0]   EVENT_INDEX,
  output logic         EVENT_LEVEL,
  output logic         OVERRUN
);
  logic [N-1:0] s1, s2, pending, plevel, accept, load;
  logic [CNT_W-1:0] cnt [N];
  logic free, sel_level;
  logic [3:0] sel;
  assign free = !EVENT_VALID || EVENT_READY;
  // lowest-numbered pending channel wins; downward scan leaves the lowest index last
  always_comb begin
    sel = '0;
    sel_level = 1'b0;
    accept = '0;
    for (int i = N - 1; i >= 0; i--) if (pending[i]) begin
      sel = 4'(i);
      sel_level = plevel[i];
    end
    for (int i = 0; i < N; i++) accept[i] = s2[i] != STATE[i] && cnt[i] == CNT_W'(STABLE_CYCLES - 1);
    load = (free && |pending) ? N'(1) << sel : '0;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      STATE <= '0;
      RISE <= '0;
      FALL <= '0;
      pending <= '0;
      plevel <= '0;
      OVERRUN <= 1'b0;
      EVENT_VALID <= 1'b0;
      EVENT_INDEX <= '0;
      EVENT_LEVEL <= 1'b0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      s1 <= SW;
      s2 <= s1;
      for (int i = 0; i < N; i++) cnt[i] <= (s2[i] == STATE[i] || accept[i]) ? '0 : cnt[i] + CNT_W'(1);
      STATE <= STATE ^ accept;
      RISE <= accept & s2;
      FALL <= accept & ~s2;
      // a fresh change beats the load of the same channel: the old level goes out, the new one stays pending
      pending <= (pending & ~load) | accept;
      plevel <= (plevel & ~accept) | (s2 & accept);
      OVERRUN <= OVERRUN | |(accept & pending & ~load);
      if (free) begin
        EVENT_VALID <= |pending;
        if (|pending) begin
          EVENT_INDEX <= sel;
          EVENT_LEVEL <= sel_level;
        end
      end
    end
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed and randomized checks of switch_debouncer against a behavioural model
module tb_switch_debouncer;
  localparam int N = 6;
  localparam int SC = 4;
  logic clock = 1'b0, reset = 1'b0, ready = 1'b1;
  logic [N-1:0] sw = '0, sw1 = '0;
  logic [N-1:0] state, rise, fall, state1, rise1, fall1;
  logic valid, level, ovr, valid1, level1, ovr1;
  logic [3:0] index, index1;
  int n_chk = 0, n_fail = 0;
  int hs_cnt [16];
  logic hs_lev [16];
  logic [N-1:0] m_sync[$], m_hist[$];
  logic [N-1:0] m_state, m_rise, m_fall, m_pend, m_plev;
  logic m_valid, m_level, m_ovr;
  logic [3:0] m_index;

  always #5 clock = ~clock;

  switch_debouncer #(.N(N), .STABLE_CYCLES(SC)) dut (
    .clock(clock), .reset(reset), .SW(sw), .STATE(state), .RISE(rise), .FALL(fall),
    .EVENT_VALID(valid), .EVENT_READY(ready), .EVENT_INDEX(index), .EVENT_LEVEL(level), .OVERRUN(ovr)
  );
  switch_debouncer #(.N(N), .STABLE_CYCLES(1)) dut1 (
    .clock(clock), .reset(reset), .SW(sw1), .STATE(state1), .RISE(rise1), .FALL(fall1),
    .EVENT_VALID(valid1), .EVENT_READY(1'b1), .EVENT_INDEX(index1), .EVENT_LEVEL(level1), .OVERRUN(ovr1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_sync.delete();
    m_sync.push_back('0);
    m_sync.push_back('0);
    m_hist.delete();
    m_state = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_plev = '0;
    m_valid = 1'b0; m_level = 1'b0; m_ovr = 1'b0; m_index = '0;
  endtask

  // a level is accepted once the last SC synchronised samples all disagree with the current level
  task automatic model_step(input logic [N-1:0] s, input logic rdy);
    logic [N-1:0] used, acc, ld;
    int lo;
    m_sync.push_back(s);
    used = m_sync.pop_front();
    m_hist.push_back(used);
    if (m_hist.size() > SC) m_hist.delete(0);
    acc = '0;
    if (m_hist.size() == SC)
      for (int i = 0; i < N; i++) begin
        acc[i] = 1'b1;
        foreach (m_hist[k]) if (m_hist[k][i] == m_state[i]) acc[i] = 1'b0;
      end
    lo = -1;
    for (int i = N - 1; i >= 0; i--) if (m_pend[i]) lo = i;
    ld = '0;
    if (!m_valid || rdy) begin
      m_valid = lo >= 0;
      if (lo >= 0) begin
        m_index = 4'(lo);
        m_level = m_plev[lo];
        ld[lo] = 1'b1;
      end
    end
    m_ovr = m_ovr | |(acc & m_pend & ~ld);
    m_pend = (m_pend & ~ld) | acc;
    for (int i = 0; i < N; i++) if (acc[i]) m_plev[i] = ~m_state[i];
    m_rise = acc & ~m_state;
    m_fall = acc & m_state;
    m_state = m_state ^ acc;
  endtask

  task automatic compare_all();
    check("state", 32'(state), 32'(m_state));
    check("rise", 32'(rise), 32'(m_rise));
    check("fall", 32'(fall), 32'(m_fall));
    check("valid", 32'(valid), 32'(m_valid));
    check("index", 32'(index), 32'(m_index));
    check("level", 32'(level), 32'(m_level));
    check("overrun", 32'(ovr), 32'(m_ovr));
    check("rf_excl1", 32'(rise1 & fall1), 0);
  endtask

  task automatic step();
    if (valid && ready) begin
      hs_cnt[index]++;
      hs_lev[index] = level;
    end
    @(posedge clock);
    if (reset) model_clear();
    else model_step(sw, ready);
    #1;
    compare_all();
  endtask

  task automatic do_reset(input int cycles);
    #2 reset = 1'b1;
    #1;
    model_clear();
    for (int i = 0; i < 16; i++) begin
      hs_cnt[i] = 0;
      hs_lev[i] = 1'b0;
    end
    check("rst_zero", 32'({state, rise, fall, valid, index, level, ovr}), 0);
    compare_all();
    repeat (cycles) step();
    #2 reset = 1'b0;
  endtask

  initial begin
    do_reset(2);
    sw = 6'b000001;
    repeat (5) step();
    check("t1_state_e5", 32'(state), 0);
    step();
    check("t1_state_e6", 32'(state), 1);
    check("t1_rise_e6", 32'(rise), 1);
    step();
    check("t1_rise_e7", 32'(rise), 0);
    check("t1_valid_e7", 32'(valid), 1);
    check("t1_index_e7", 32'(index), 0);
    check("t1_level_e7", 32'(level), 1);

    sw = '0;
    do_reset(2);
    for (int k = 0; k < 4; k++) begin
      sw[2] = (k % 2 == 0);
      step();
      check("t2_bounce", 32'(state[2]), 0);
    end
    sw[2] = 1'b1;
    repeat (5) begin
      step();
      check("t2_settle", 32'(state[2]), 0);
    end
    step();
    check("t2_state_e6", 32'(state[2]), 1);
    repeat (8) step();
    check("t2_one_event", 32'(hs_cnt[2]), 1);

    sw = '0;
    do_reset(2);
    ready = 1'b0;
    sw = 6'b100001;
    repeat (7) step();
    for (int k = 0; k < 10; k++) begin
      check("t3_hold_valid", 32'(valid), 1);
      check("t3_hold_index", 32'(index), 0);
      step();
    end
    check("t3_hold_valid_end", 32'(valid), 1);
    ready = 1'b1;
    step();
    check("t3_next_valid", 32'(valid), 1);
    check("t3_next_index", 32'(index), 5);
    step();
    check("t3_drain", 32'(valid), 0);

    sw = '0;
    do_reset(2);
    ready = 1'b0;
    sw = 6'b000001;
    repeat (7) step();
    check("t4_ch0_valid", 32'(valid), 1);
    sw[3] = 1'b1;
    repeat (7) step();
    check("t4_no_ovr_yet", 32'(ovr), 0);
    sw[3] = 1'b0;
    repeat (7) step();
    check("t4_ovr", 32'(ovr), 1);
    ready = 1'b1;
    step();
    check("t4_ev3_index", 32'(index), 3);
    check("t4_ev3_level", 32'(level), 0);
    repeat (4) step();
    check("t4_ev3_count", 32'(hs_cnt[3]), 1);
    check("t4_ev3_lev", 32'(hs_lev[3]), 0);
    check("t4_drained", 32'(valid), 0);

    sw = '0;
    do_reset(2);
    sw = 6'b000010;
    repeat (4) step();
    do_reset(2);
    repeat (5) begin
      step();
      check("t5_relatency", 32'(state[1]), 0);
    end
    step();
    check("t5_state_e6", 32'(state[1]), 1);
    ready = 1'b0;
    step();
    check("t5_mid_hs_valid", 32'(valid), 1);
    do_reset(1);
    ready = 1'b1;
    repeat (8) step();

    sw = '0;
    do_reset(2);
    sw1 = 6'b000100;
    repeat (2) step();
    check("t6_sc1_hold", 32'(state1), 0);
    step();
    check("t6_sc1_rise_state", 32'(state1), 4);
    check("t6_sc1_rise", 32'(rise1), 4);
    sw1 = '0;
    repeat (2) step();
    check("t6_sc1_hold_hi", 32'(state1), 4);
    step();
    check("t6_sc1_fall_state", 32'(state1), 0);
    check("t6_sc1_fall", 32'(fall1), 4);

    for (int c = 0; c < 4000; c++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) sw = N'($urandom);
      else if (r < 15) sw[$urandom_range(0, N - 1)] ^= 1'b1;
      if ($urandom_range(0, 9) == 0) sw1 = N'($urandom);
      ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 999) == 0) do_reset(1);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/switch_debouncer.md
# switch_debouncer

Conditions the board's slide switches and pushbuttons before any logic uses them. The block takes up to N raw, bouncing, asynchronous contacts, synchronises them, and debounces each channel with a stability counter. It presents a clean level per channel, one-cycle rise and fall strobes, and a queued change-event stream with a valid/ready handshake. It sits between the board input pins and the display and control logic that consumes switch state.

## Interface
Parameters:
- N, 6, number of input channels (1..16).
- STABLE_CYCLES, 50000, consecutive stable clock cycles required to accept a new level (1 ms at 50 MHz); minimum 1.
- CNT_W, $clog2(STABLE_CYCLES+1), width of each per-channel counter.

Ports:
- clock  input  1  single system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- SW  input  N  raw switch/key contacts; asynchronous to clock; may bounce.
- STATE  output  N  debounced level per channel.
- RISE  output  N  one-cycle strobe: channel's STATE went 0→1 on this edge.
- FALL  output  N  one-cycle strobe: channel's STATE went 1→0 on this edge.
- EVENT_VALID  output  1  an event is presented.
- EVENT_READY  input  1  consumer accepts the presented event.
- EVENT_INDEX  output  4  channel number of the presented event.
- EVENT_LEVEL  output  1  new debounced level of that channel.
- OVERRUN  output  1  sticky: an unconsumed event was overwritten.

## Operation
- Synchroniser: two flops per channel, SW → s1 → s2. Only s2 is used downstream.
- Debounce per channel i:
  - if s2[i] == STATE[i]: cnt[i] ← 0.
  - else if cnt[i] == STABLE_CYCLES-1: STATE[i] ← s2[i], cnt[i] ← 0, assert RISE[i] or FALL[i] for one cycle.
  - else: cnt[i] ← cnt[i]+1.
  - Any bounce back to STATE[i] before acceptance restarts the count from 0.
  - The counter never wraps.
- Event queue:
  - On each STATE[i] change, pending[i] ← 1 and plevel[i] ← new level.
  - If pending[i] was already set and is not being loaded on that edge, OVERRUN ← 1 and plevel[i] is overwritten. Only the latest level survives.
- Output register, when EVENT_VALID == 0 or (EVENT_VALID && EVENT_READY):
  - If any pending bit is set, load the lowest-numbered pending channel into EVENT_INDEX/EVENT_LEVEL, clear its pending bit, and set EVENT_VALID ← 1.
  - Otherwise EVENT_VALID ← 0.
- Simultaneous set and load on the same channel: load takes the old plevel; the set wins, so pending stays 1 with the new level. The result is a second event, not an overrun.
- Handshake:
  - While EVENT_VALID && !EVENT_READY, EVENT_VALID, EVENT_INDEX and EVENT_LEVEL hold constant.
  - EVENT_READY with EVENT_VALID == 0 is ignored.
- Reset (any time, including mid-count or mid-handshake) clears immediately:
  - s1, s2, STATE, cnt, pending, plevel, RISE, FALL, EVENT_VALID, EVENT_INDEX, EVENT_LEVEL and OVERRUN all go to 0.
  - A switch held high through reset produces a normal rise and event after release.

## Timing
- SW step to STATE change: 2 synchroniser edges + STABLE_CYCLES edges = STABLE_CYCLES+2 edges, given no bounce.
- RISE/FALL are asserted in the same cycle STATE first shows the new value.
- EVENT_VALID rises 1 edge after the STATE change when the output register is free.
- Back-to-back events are possible: a new event loads on the accepting edge, so there are no idle cycles.
- Acceptance order follows index priority, not time order, among simultaneously pending channels.
- All outputs are registered. There is no combinational path from SW or EVENT_READY to any output.

## Test plan
Benches use N=6, STABLE_CYCLES=4, and EVENT_READY=1 unless stated.

- Reset then SW=6'b000001 held steady:
  - STATE[0]=1 and RISE[0]=1 (1 cycle) at edge 6.
  - EVENT_VALID=1, INDEX=0, LEVEL=1 at edge 7.
- SW[2] toggles 1,0,1,0 every cycle, then holds 1:
  - STATE[2] stays 0 during the bounce.
  - STATE[2] goes to 1 exactly 6 edges after the final transition; exactly one event.
- SW=6'b100001 at once with EVENT_READY=0:
  - VALID=1, INDEX=0, held for 10 cycles.
  - Raise READY: INDEX=5 on the next edge, then VALID=0.
- With READY=0 and channel 3's event pending (not presented), toggle SW[3] up then down, stable each time:
  - OVERRUN=1; a single event for channel 3 with LEVEL=0.
- Assert reset mid-count (cnt=2) and mid-handshake (VALID=1):
  - All outputs are 0 during reset.
  - After release, the held switch produces a full 6-edge latency before STATE changes.
- STABLE_CYCLES=1:
  - STATE follows a clean SW step in 3 edges; RISE and FALL never both asserted.
